// File: rtl/servo_pwm_multi_if.sv
// Command bus into the multi-channel servo PWM block: per-channel enables,
// inc/dec pulses and the direct target-load strobe.
interface servo_pwm_multi_if #(
  parameter int N_CH  = 4,
  parameter int POS_W = 8
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]  enable;
  logic [N_CH-1:0]  inc_req;
  logic [N_CH-1:0]  dec_req;
  logic             load_valid;
  logic [CH_W-1:0]  load_ch;
  logic [POS_W-1:0] load_pos;

  modport master (output enable, inc_req, dec_req, load_valid, load_ch, load_pos);
  modport slave  (input  enable, inc_req, dec_req, load_valid, load_ch, load_pos);
endinterface

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM: shared frame counter, per-channel target/current position
// with per-frame slew, widths latched at the frame boundary for glitch-free pulses.
module servo_pwm_multi #(
  parameter int N_CH       = 4,
  parameter int PERIOD     = 1_000_000,
  parameter int PULSE_MIN  = 25_000,
  parameter int PULSE_STEP = 1_000,
  parameter int POS_MAX    = 100,
  parameter int POS_W      = 8,
  parameter int STEP       = 5,
  parameter int SLEW       = 2,
  parameter int POS_RST    = 0,
  parameter int CNT_W      = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  servo_pwm_multi_if.slave        cmd,
  output logic [N_CH-1:0]         pwm_out,
  output logic [N_CH*POS_W-1:0]   cur_pos,
  output logic [N_CH-1:0]         busy,
  output logic                    frame_tick
);
  localparam int                CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0]  LAST      = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  PMIN_C    = CNT_W'(PULSE_MIN);
  localparam logic [CNT_W-1:0]  PSTEP_C   = CNT_W'(PULSE_STEP);
  localparam logic [CNT_W-1:0]  WIDTH_RST = CNT_W'(PULSE_MIN + POS_RST * PULSE_STEP);
  localparam logic [POS_W:0]    POS_MAX_X = (POS_W + 1)'(POS_MAX);
  localparam logic [POS_W:0]    STEP_X    = (POS_W + 1)'(STEP);
  localparam logic [POS_W-1:0]  POS_MAX_P = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0]  POS_RST_P = POS_W'(POS_RST);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             frame_tick_reg;

  assign cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + CNT_W'(1);

  // frame_tick is registered so it lines up with counter == PERIOD-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg        <= '0;
      frame_tick_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      frame_tick_reg <= (cnt_next == LAST);
    end
  end

  assign frame_tick = frame_tick_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [POS_W-1:0] target_reg;
      logic [POS_W-1:0] target_next;
      logic [POS_W-1:0] cur_reg;
      logic [POS_W-1:0] cur_next;
      logic [CNT_W-1:0] width_reg;
      logic             pwm_reg;
      logic [POS_W:0]   tgt_x;
      logic [POS_W:0]   inc_x;
      logic [POS_W:0]   dec_x;
      logic [POS_W:0]   load_x;
      logic             load_hit;

      assign tgt_x    = {1'b0, target_reg};
      assign inc_x    = tgt_x + STEP_X;
      assign dec_x    = tgt_x - STEP_X;
      assign load_x   = {1'b0, cmd.load_pos};
      assign load_hit = cmd.load_valid && (cmd.load_ch == CH_W'(gi));

      always_comb begin
        target_next = target_reg;
        if (load_hit)
          target_next = (load_x > POS_MAX_X) ? POS_MAX_P : cmd.load_pos;
        else if (cmd.inc_req[gi] && cmd.dec_req[gi])
          target_next = target_reg;
        else if (cmd.inc_req[gi])
          target_next = (inc_x > POS_MAX_X) ? POS_MAX_P : inc_x[POS_W-1:0];
        else if (cmd.dec_req[gi])
          target_next = (tgt_x < STEP_X) ? '0 : dec_x[POS_W-1:0];
      end

      if (SLEW == 0) begin : g_jump
        assign cur_next = target_reg;
      end else begin : g_slew
        localparam logic [POS_W:0] SLEW_X = (POS_W + 1)'(SLEW);
        logic [POS_W:0] cur_x;
        logic [POS_W:0] up_x;
        logic [POS_W:0] dn_x;

        assign cur_x = {1'b0, cur_reg};
        assign up_x  = cur_x + SLEW_X;
        assign dn_x  = cur_x - SLEW_X;

        always_comb begin
          cur_next = cur_reg;
          if (tgt_x > cur_x)
            cur_next = ((tgt_x - cur_x) > SLEW_X) ? up_x[POS_W-1:0] : target_reg;
          else if (cur_x > tgt_x)
            cur_next = ((cur_x - tgt_x) > SLEW_X) ? dn_x[POS_W-1:0] : target_reg;
        end
      end

      // Slew and width latch share the frame_tick edge, so the width used from
      // count 0 onward always reflects the position just slewed.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          target_reg <= POS_RST_P;
          cur_reg    <= POS_RST_P;
          width_reg  <= WIDTH_RST;
          pwm_reg    <= 1'b0;
        end else begin
          target_reg <= target_next;
          if (frame_tick_reg) begin
            cur_reg   <= cur_next;
            width_reg <= PMIN_C + CNT_W'(cur_next) * PSTEP_C;
          end
          pwm_reg <= cmd.enable[gi] && (cnt_reg < width_reg);
        end
      end

      assign pwm_out[gi]                 = pwm_reg;
      assign cur_pos[gi*POS_W +: POS_W]  = cur_reg;
      assign busy[gi]                    = (cur_reg != target_reg);
    end
  endgenerate

  param_legal_a: assert property (@(posedge clk)
    (PULSE_MIN + POS_MAX * PULSE_STEP < PERIOD) && (POS_MAX < 2 ** POS_W));

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: a SLEW=2 two-channel unit and a SLEW=0 three-channel
// unit run in lockstep; per-frame expectations go into queues checked by a monitor.
module tb_servo_pwm_multi;
  localparam int PERIOD = 200;
  localparam int NF     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  servo_pwm_multi_if #(.N_CH(2), .POS_W(8)) ifa ();
  servo_pwm_multi_if #(.N_CH(3), .POS_W(8)) ifb ();

  logic [1:0]  pwm_a, busy_a;
  logic [15:0] cur_a;
  logic        tick_a;
  logic [2:0]  pwm_b, busy_b;
  logic [23:0] cur_b;
  logic        tick_b;

  servo_pwm_multi #(
    .N_CH(2), .PERIOD(PERIOD), .PULSE_MIN(20), .PULSE_STEP(1), .POS_MAX(100),
    .POS_W(8), .STEP(5), .SLEW(2), .POS_RST(0), .CNT_W(20)
  ) dut_a (
    .clk(clk), .rst(rst), .cmd(ifa),
    .pwm_out(pwm_a), .cur_pos(cur_a), .busy(busy_a), .frame_tick(tick_a)
  );

  servo_pwm_multi #(
    .N_CH(3), .PERIOD(PERIOD), .PULSE_MIN(20), .PULSE_STEP(1), .POS_MAX(100),
    .POS_W(8), .STEP(5), .SLEW(0), .POS_RST(0), .CNT_W(20)
  ) dut_b (
    .clk(clk), .rst(rst), .cmd(ifb),
    .pwm_out(pwm_b), .cur_pos(cur_b), .busy(busy_b), .frame_tick(tick_b)
  );

  typedef struct packed {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    logic [7:0]  c0;
    logic [7:0]  c1;
    logic [2:0]  busy;
  } rec_t;

  rec_t qa[$];
  rec_t qb[$];
  int checks = 0;
  int errors = 0;
  int cpos   = 0;

  // Hand-computed per-frame expectations (pulse width measured in the frame,
  // position and busy at the end of the frame before the slew).
  int a_w0[NF]   = '{20, 20, 22, 24, 25, 25, 25, 10};
  int a_c0[NF]   = '{ 0,  0,  2,  4,  5,  5,  5,  5};
  int a_bz[NF]   = '{ 0,  1,  1,  1,  0,  0,  0,  0};
  int b_w0[NF]   = '{20, 20, 120, 120, 120, 120, 120, 120};
  int b_c0[NF]   = '{ 0,  0, 100, 100, 100, 100, 100, 100};
  int b_bz[NF]   = '{ 0,  1,  0,  0,  0,  0,  0,  0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int aw0, input int ac0, input int abz,
                      input int bw0, input int bc0, input int bbz);
    rec_t r;
    r = '{w0: 16'(aw0), w1: 16'd20, w2: 16'd0, c0: 8'(ac0), c1: 8'd0, busy: 3'(abz)};
    qa.push_back(r);
    r = '{w0: 16'(bw0), w1: 16'd20, w2: 16'd20, c0: 8'(bc0), c1: 8'd0, busy: 3'(bbz)};
    qb.push_back(r);
  endtask

  // Frame monitor: accumulates high cycles and compares at each frame_tick.
  initial begin
    int hi_a[2];
    int hi_b[3];
    int per_cnt;
    int fno;
    bit seen;
    rec_t r;
    per_cnt = 0; fno = 0; seen = 1'b0;
    foreach (hi_a[i]) hi_a[i] = 0;
    foreach (hi_b[i]) hi_b[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        foreach (hi_a[i]) hi_a[i] = 0;
        foreach (hi_b[i]) hi_b[i] = 0;
        per_cnt = 0;
        seen = 1'b0;
      end else begin
        per_cnt++;
        for (int i = 0; i < 2; i++) hi_a[i] += int'(pwm_a[i]);
        for (int i = 0; i < 3; i++) hi_b[i] += int'(pwm_b[i]);
        if (tick_a) begin
          chk("tick_b_aligned", int'(tick_b), 1);
          if (seen) chk("frame_period", per_cnt, PERIOD);
          seen = 1'b1;
          per_cnt = 0;
          if (qa.size() > 0) begin
            r = qa.pop_front();
            chk("a_width0", hi_a[0], int'(r.w0));
            chk("a_width1", hi_a[1], int'(r.w1));
            chk("a_cur0", int'(cur_a[7:0]), int'(r.c0));
            chk("a_cur1", int'(cur_a[15:8]), int'(r.c1));
            chk("a_busy", int'(busy_a), int'(r.busy[1:0]));
            $display("frame %0d A: width=%0d/%0d cur=%0d/%0d busy=%b", fno,
                     hi_a[0], hi_a[1], cur_a[7:0], cur_a[15:8], busy_a);
          end
          if (qb.size() > 0) begin
            r = qb.pop_front();
            chk("b_width0", hi_b[0], int'(r.w0));
            chk("b_width1", hi_b[1], int'(r.w1));
            chk("b_width2", hi_b[2], int'(r.w2));
            chk("b_cur0", int'(cur_b[7:0]), int'(r.c0));
            chk("b_busy", int'(busy_b), int'(r.busy));
            $display("frame %0d B: width=%0d/%0d/%0d cur0=%0d busy=%b", fno,
                     hi_b[0], hi_b[1], hi_b[2], cur_b[7:0], busy_b);
          end
          fno++;
          foreach (hi_a[i]) hi_a[i] = 0;
          foreach (hi_b[i]) hi_b[i] = 0;
        end
      end
    end
  end

  // Reset monitor: outputs must clear asynchronously on every reset assertion.
  initial begin
    forever begin
      @(negedge rst);
      #1;
      chk("rst_pwm_a", int'(pwm_a), 0);
      chk("rst_pwm_b", int'(pwm_b), 0);
      chk("rst_busy_a", int'(busy_a), 0);
      chk("rst_busy_b", int'(busy_b), 0);
      chk("rst_tick_a", int'(tick_a), 0);
      chk("rst_cur_a", int'(cur_a), 0);
      chk("rst_cur_b", int'(cur_b), 0);
      $display("reset: pwm=%b/%b busy=%b/%b cur=%h/%h", pwm_a, pwm_b, busy_a, busy_b, cur_a, cur_b);
    end
  end

  task automatic step();
    @(negedge clk);
    cpos = (cpos + 1) % PERIOD;
  endtask

  task automatic goto(input int c);
    while (cpos != c) step();
  endtask

  task automatic idle();
    ifa.inc_req = '0; ifa.dec_req = '0; ifa.load_valid = 1'b0;
    ifb.inc_req = '0; ifb.dec_req = '0; ifb.load_valid = 1'b0;
  endtask

  task automatic load_a(input int ch, input int pos);
    ifa.load_valid = 1'b1; ifa.load_ch = 1'(ch); ifa.load_pos = 8'(pos);
    step(); idle();
  endtask

  task automatic load_b(input int ch, input int pos);
    ifb.load_valid = 1'b1; ifb.load_ch = 2'(ch); ifb.load_pos = 8'(pos);
    step(); idle();
  endtask

  task automatic dec_a(input int ch, input int n);
    repeat (n) begin
      ifa.dec_req[ch] = 1'b1;
      step(); idle();
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_a && n < 2 * PERIOD);
    if (!tick_a) begin
      checks++; errors++;
      $display("FAIL frame_tick_timeout actual=0 required=1");
    end
    cpos = PERIOD - 1;
  endtask

  initial begin
    ifa.enable = 2'b11; ifb.enable = 3'b111;
    ifa.load_ch = '0; ifa.load_pos = '0; ifb.load_ch = '0; ifb.load_pos = '0;
    idle();
    #3 rst = 1'b0;
    #9 rst = 1'b1;
    cpos = 0;

    for (int f = 0; f < NF; f++) begin
      push(a_w0[f], a_c0[f], a_bz[f], b_w0[f], b_c0[f], b_bz[f]);
      case (f)
        1: begin
          goto(50);
          ifa.inc_req[0] = 1'b1;
          load_b(0, 100);
          load_b(3, 50);
        end
        3: begin goto(50); load_a(1, 200); dec_a(1, 20); end
        4: begin
          goto(50); load_a(1, 98);
          ifa.inc_req[1] = 1'b1; step(); idle();
          dec_a(1, 20);
        end
        5: begin
          goto(50); dec_a(1, 1);
          ifa.inc_req[0] = 1'b1; ifa.dec_req[0] = 1'b1; step(); idle();
        end
        6: begin
          goto(50);
          ifa.load_valid = 1'b1; ifa.load_ch = 1'b0; ifa.load_pos = 8'd50;
          ifa.inc_req[0] = 1'b1; step(); idle();
          dec_a(0, 9);
        end
        7: begin goto(10); ifa.enable[0] = 1'b0; goto(100); ifa.enable[0] = 1'b1; end
        default: ;
      endcase
      wait_tick();
    end

    goto(5);
    ifa.inc_req[0] = 1'b1; step(); idle();
    goto(10);
    rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    cpos = 0;
    for (int f = 0; f < 2; f++) begin
      push(20, 0, 0, 20, 0, 0);
      wait_tick();
    end

    step(); step();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
